// File: rtl/fg_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fg_prog_pkg
// Purpose  : Shared types and state codes for the floating-gate programming
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fg_prog_pkg;

    typedef enum logic [1:0] {
        OP_PROG  = 2'b00,
        OP_ERASE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_LIMIT   = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_ABORT   = 2'b11
    } status_e;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] MEAS   = 3'd2;
    localparam logic [2:0] PULSE  = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fg_prog_timer.sv
`default_nettype none
// ============================================================================
// Module   : fg_prog_timer
// Purpose  : Loadable down-counter with zero flag, shared by the settle,
//            pulse-width and measurement-timeout intervals.
// Revision : 1.0 - initial release
// ============================================================================
module fg_prog_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fg_prog_sequencer
// Purpose  : Measure/pulse/settle programming loop for one FPAA switch element.
//            Optional macro PROG_STATS_EN adds the rsp_pulses output.
// Revision : 1.0 - initial release
// ============================================================================
module fg_prog_sequencer
    import fg_prog_pkg::*;
#(
    parameter int ISL_W        = 2,
    parameter int ROW_W        = 4,
    parameter int COL_W        = 5,
    parameter int PCNT_W       = 8,
    parameter int MAX_PULSES   = 200,
    parameter int PULSE_CYC    = 16,
    parameter int SETTLE_CYC   = 4,
    parameter int MEAS_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ISL_W-1:0] cmd_island,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    input  logic             cmd_abort,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             rsp_hit,
    output logic [ISL_W-1:0] island_sel,
    output logic [ROW_W-1:0] row_sel,
    output logic [COL_W-1:0] col_sel,
    output logic             mux_en,
    output logic             vinj_en,
    output logic             vtun_en,
    output logic             meas_start,
    input  logic             meas_done,
    input  logic             meas_hit
`ifdef PROG_STATS_EN
    ,
    output logic [PCNT_W-1:0] rsp_pulses
`endif
);

    localparam int c_tmr_w = $clog2(max3(SETTLE_CYC, PULSE_CYC, MEAS_TIMEOUT) + 1);
    localparam logic [c_tmr_w-1:0] c_ld_settle = c_tmr_w'(SETTLE_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_ld_pulse  = c_tmr_w'(PULSE_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_ld_meas   = c_tmr_w'(MEAS_TIMEOUT - 1);
    localparam logic [PCNT_W-1:0]  c_pcnt_max  = PCNT_W'(MAX_PULSES);

    logic [2:0]         r_state, w_nxt;
    op_e                r_op;
    status_e            r_status, w_status;
    logic [PCNT_W-1:0]  r_pcnt;
    logic               r_hit, r_meas_start;
    logic [ISL_W-1:0]   r_isl;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic               w_accept, w_active, w_is_read;
    logic               w_tmr_zero, w_tmr_load;
    logic [c_tmr_w-1:0] w_tmr_val;

    assign w_accept  = cmd_valid && (r_state == IDLE);
    assign w_active  = (r_state == SETUP) || (r_state == MEAS) ||
                       (r_state == PULSE) || (r_state == SETTLE);
    assign w_is_read = (r_op == OP_READ) || (r_op == OP_RSVD);

    always_comb begin
        w_nxt    = r_state;
        w_status = r_status;
        case (r_state)
            IDLE:   if (cmd_valid) w_nxt = SETUP;
            SETUP:  if (w_tmr_zero) w_nxt = MEAS;
            MEAS: begin
                // A completion on the last timeout cycle takes priority.
                if (meas_done) begin
                    if (meas_hit || w_is_read) begin
                        w_nxt    = RESP;
                        w_status = ST_OK;
                    end else if (r_pcnt == c_pcnt_max) begin
                        w_nxt    = RESP;
                        w_status = ST_LIMIT;
                    end else begin
                        w_nxt = PULSE;
                    end
                end else if (w_tmr_zero) begin
                    w_nxt    = RESP;
                    w_status = ST_TIMEOUT;
                end
            end
            PULSE:  if (w_tmr_zero) w_nxt = SETTLE;
            SETTLE: if (w_tmr_zero) w_nxt = MEAS;
            RESP:   if (rsp_ready) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (cmd_abort && w_active) begin
            w_nxt    = RESP;
            w_status = ST_ABORT;
        end
    end

    // Every state change reloads the shared timer with the interval of the
    // state being entered.
    always_comb begin
        w_tmr_load = (w_nxt != r_state);
        case (w_nxt)
            SETUP, SETTLE: w_tmr_val = c_ld_settle;
            MEAS:          w_tmr_val = c_ld_meas;
            PULSE:         w_tmr_val = c_ld_pulse;
            default:       w_tmr_val = '0;
        endcase
    end

    fg_prog_timer #(
        .WIDTH(c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= OP_PROG;
            r_status     <= ST_OK;
            r_pcnt       <= '0;
            r_hit        <= 1'b0;
            r_meas_start <= 1'b0;
            r_isl        <= '0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            r_state      <= w_nxt;
            r_status     <= w_status;
            r_meas_start <= (w_nxt == MEAS) && (r_state != MEAS);
            if (w_accept) begin
                r_op   <= op_e'(cmd_op);
                r_isl  <= cmd_island;
                r_row  <= cmd_row;
                r_col  <= cmd_col;
                r_pcnt <= '0;
                r_hit  <= 1'b0;
            end else if ((r_state == MEAS) && (w_nxt == PULSE) && (r_pcnt != '1)) begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if ((r_state == MEAS) && meas_done) begin
                r_hit <= meas_hit;
            end
        end
    end

    // Pulse enables decode straight from state so an asynchronous reset
    // removes them without waiting for a clock.
    assign cmd_ready  = (r_state == IDLE);
    assign mux_en     = (r_state != IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign vinj_en    = (r_state == PULSE) && (r_op == OP_PROG);
    assign vtun_en    = (r_state == PULSE) && (r_op == OP_ERASE);
    assign meas_start = r_meas_start;
    assign rsp_status = r_status;
    assign rsp_hit    = r_hit;
    assign island_sel = r_isl;
    assign row_sel    = r_row;
    assign col_sel    = r_col;

`ifdef PROG_STATS_EN
    assign rsp_pulses = r_pcnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fg_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fg_prog_sequencer
// Purpose  : Directed self-checking bench for fg_prog_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fg_prog_sequencer;

    localparam int ISL_W  = 2;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 5;
    localparam int PCNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_abort;
    logic [1:0]       cmd_op;
    logic [ISL_W-1:0] cmd_island;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic             rsp_valid, rsp_ready, rsp_hit;
    logic [1:0]       rsp_status;
    logic [ISL_W-1:0] island_sel;
    logic [ROW_W-1:0] row_sel;
    logic [COL_W-1:0] col_sel;
    logic             mux_en, vinj_en, vtun_en, meas_start, meas_done, meas_hit;
`ifdef PROG_STATS_EN
    logic [PCNT_W-1:0] rsp_pulses;
`endif

    fg_prog_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_island (cmd_island),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_abort  (cmd_abort),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_hit    (rsp_hit),
        .island_sel (island_sel),
        .row_sel    (row_sel),
        .col_sel    (col_sel),
        .mux_en     (mux_en),
        .vinj_en    (vinj_en),
        .vtun_en    (vtun_en),
        .meas_start (meas_start),
        .meas_done  (meas_done),
        .meas_hit   (meas_hit)
`ifdef PROG_STATS_EN
        ,
        .rsp_pulses (rsp_pulses)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int n_inj, n_tun, bad_w, viol, ms_cyc, rsp_cyc;
    logic [ISL_W-1:0] exp_isl;
    logic [ROW_W-1:0] exp_row;
    logic [COL_W-1:0] exp_col;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input int isl, input int row, input int col);
        exp_isl    = ISL_W'(isl);
        exp_row    = ROW_W'(row);
        exp_col    = COL_W'(col);
        cmd_op     = op;
        cmd_island = ISL_W'(isl);
        cmd_row    = ROW_W'(row);
        cmd_col    = COL_W'(col);
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Cycle-by-cycle observer and comparator model until a response appears.
    task automatic run_cmd(input int hit_from, input bit respond, input int abort_at,
                           input int rst_at, input int budget);
        int  cd, midx, wcnt, cyc;
        bit  prev_inj, prev_tun, ab_pend, done;
        cd = 0; midx = 0; wcnt = 0; cyc = 0;
        prev_inj = 0; prev_tun = 0; ab_pend = 0; done = 0;
        n_inj = 0; n_tun = 0; bad_w = 0; viol = 0; ms_cyc = -1; rsp_cyc = -1;
        while (!done) begin
            if (ab_pend) begin
                chk("abort_vinj_next", vinj_en, 0);
                ab_pend = 0;
            end
            if (vinj_en && !prev_inj) n_inj++;
            if (vtun_en && !prev_tun) n_tun++;
            if (vinj_en || vtun_en) begin
                wcnt++;
            end else begin
                if ((prev_inj || prev_tun) && wcnt != 16 && abort_at == 0) bad_w++;
                wcnt = 0;
            end
            if ((vinj_en && vtun_en) || ((vinj_en || vtun_en) && !mux_en) ||
                island_sel !== exp_isl || row_sel !== exp_row || col_sel !== exp_col)
                viol++;
            if (meas_start && ms_cyc < 0) ms_cyc = cyc;
            if (rsp_valid) begin
                rsp_cyc = cyc;
                done = 1;
            end else if (rst_at != 0 && vinj_en && wcnt == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_async_vinj", vinj_en, 0);
                chk("rst_async_mux", mux_en, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                done = 1;
            end else if (cyc >= budget) begin
                chk("run_budget_rsp", rsp_valid, 1);
                done = 1;
            end else begin
                cmd_abort = 1'b0;
                if (abort_at != 0 && vinj_en && n_inj == 1 && wcnt == abort_at) begin
                    cmd_abort = 1'b1;
                    ab_pend   = 1;
                end
                meas_done = 1'b0;
                meas_hit  = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        meas_done = 1'b1;
                        meas_hit  = (midx >= hit_from);
                        midx++;
                    end
                end
                if (meas_start && respond) cd = 2;
                prev_inj = vinj_en;
                prev_tun = vtun_en;
                @(negedge clk);
                cyc++;
            end
        end
        cmd_abort = 1'b0;
        meas_done = 1'b0;
        meas_hit  = 1'b0;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_mux_off"}, mux_en, 0);
        chk({tag, "_rsp_clear"}, rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst = 1'b1; cmd_valid = 0; cmd_abort = 0; cmd_op = 0;
        cmd_island = 0; cmd_row = 0; cmd_col = 0;
        rsp_ready = 0; meas_done = 0; meas_hit = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_mux_en", mux_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_pulses", {vinj_en, vtun_en, meas_start}, 0);
        chk("reset_status", rsp_status, 0);

        // 1: program, miss twice then hit
        send_cmd(2'b00, 1, 3, 7);
        run_cmd(2, 1, 0, 0, 2000);
        chk("t1_inj_pulses", n_inj, 2);
        chk("t1_tun_pulses", n_tun, 0);
        chk("t1_pulse_width", bad_w, 0);
        chk("t1_invariants", viol, 0);
        chk("t1_status", rsp_status, 0);
        chk("t1_hit", rsp_hit, 1);
        chk("t1_sel", {island_sel, row_sel, col_sel}, {2'd1, 4'd3, 5'd7});
`ifdef PROG_STATS_EN
        chk("t1_rsp_pulses", rsp_pulses, 2);
`endif
        finish_rsp("t1");

        // 2: erase, never reaches target
        send_cmd(2'b01, 2, 5, 20);
        run_cmd(1000, 1, 0, 0, 20000);
        chk("t2_tun_pulses", n_tun, 200);
        chk("t2_inj_pulses", n_inj, 0);
        chk("t2_pulse_width", bad_w, 0);
        chk("t2_invariants", viol, 0);
        chk("t2_status", rsp_status, 1);
        chk("t2_hit", rsp_hit, 0);
        finish_rsp("t2");

        // 3: read, measurement never completes
        send_cmd(2'b10, 3, 15, 31);
        run_cmd(0, 0, 0, 0, 500);
        chk("t3_status", rsp_status, 2);
        chk("t3_timeout_latency", rsp_cyc - ms_cyc, 64);
        chk("t3_pulses", n_inj + n_tun, 0);
        finish_rsp("t3");

        // 4: abort during fifth cycle of the first pulse
        send_cmd(2'b00, 0, 9, 12);
        run_cmd(1000, 1, 5, 0, 2000);
        chk("t4_status", rsp_status, 3);
        chk("t4_inj_pulses", n_inj, 1);
        chk("t4_invariants", viol, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!mux_en || !rsp_valid || vinj_en) bad++;
        end
        chk("t4_mux_held", bad, 0);
        finish_rsp("t4");

        // 5: asynchronous reset in the middle of a pulse
        send_cmd(2'b00, 1, 1, 1);
        run_cmd(1000, 1, 0, 3, 2000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_mux_off", mux_en, 0);

        // 6: reserved op acts as read; response stalled for 10 cycles
        send_cmd(2'b11, 2, 6, 4);
        run_cmd(1000, 1, 0, 0, 500);
        chk("t6_status", rsp_status, 0);
        chk("t6_pulses", n_inj + n_tun, 0);
        cmd_op = 2'b10; cmd_island = 2'd1; cmd_row = 4'd9; cmd_col = 5'd2;
        cmd_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status !== 2'd0 || cmd_ready || row_sel !== 4'd6) bad++;
        end
        chk("t6_stall_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t6_ready_after_hs", cmd_ready, 1);
        chk("t6_sel_not_yet", row_sel, 6);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t6_accepted", cmd_ready, 0);
        chk("t6_new_sel", {island_sel, row_sel, col_sel}, {2'd1, 4'd9, 5'd2});
        exp_isl = 2'd1; exp_row = 4'd9; exp_col = 5'd2;
        run_cmd(0, 1, 0, 0, 500);
        chk("t6b_status", rsp_status, 0);
        finish_rsp("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
